// File: rtl/tt_serial_frame_tx.sv
// Purpose : serial framed transmitter: start bit, 4 data bits LSB-first, parity, stop bit(s).
// Latency : tx_line drops on the clock edge that sees the start rising edge; frame = (6+STOP_BITS)*BIT_CYCLES clocks.
// Backpr. : none; start edges seen while a frame is in flight are dropped, never queued.
//
// Ports (8-in/8-out user-module packaging):
//    io_in[0]    clk           single clock, rising edge
//    io_in[1]    rst           synchronous, active-high reset
//    io_in[2]    start         rising edge launches a frame
//    io_in[6:3]  data          nibble to send, sampled on the accepting edge
//    io_in[7]    parity_odd    0 = even parity, 1 = odd parity, sampled with data
//    io_out[0]   tx_line       serial output, idles high
//    io_out[1]   busy          high from frame accept through the last stop-bit cycle
//    io_out[2]   done          one-cycle pulse when the frame completes
//    io_out[3]   bit_strobe    one-cycle pulse on the first clock of every serial bit
//    io_out[6:4] state         IDLE=0 START=1 DATA=2 PARITY=3 STOP=4 (bring-up scripts decode this)
//    io_out[7]   parity        parity bit of the current / last frame

module tt_serial_frame_tx #(
   parameter int BIT_CYCLES = 4,   // clocks per serial bit, 1..255
   parameter int STOP_BITS  = 1    // 1 or 2
) (
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   // The state code appears on io_out[6:4]; the encoding must not change.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   localparam logic [7:0] LP_DIV_LAST  = 8'(BIT_CYCLES - 1);
   localparam logic [1:0] LP_STOP_LAST = 2'(STOP_BITS - 1);

   // ------------------------------------------------------------------
   // Input unpacking
   // ------------------------------------------------------------------
   logic       w_clk;
   logic       w_rst;
   logic       w_start;
   logic [3:0] w_data;
   logic       w_parity_odd;

   assign w_clk        = io_in[0];
   assign w_rst        = io_in[1];
   assign w_start      = io_in[2];
   assign w_data       = io_in[6:3];
   assign w_parity_odd = io_in[7];

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t     r_state;
   logic [7:0] r_div;        // clock divider within one serial bit, 0..BIT_CYCLES-1
   logic [1:0] r_cnt;        // data-bit index in DATA, stop-bit index in STOP
   logic [3:0] r_data;
   logic       r_parity;
   logic       r_tx;
   logic       r_busy;
   logic       r_done;
   logic       r_strobe;
   logic       r_start_q;    // resets to 1 so a start held through reset is not an edge

   state_t     w_state_nxt;
   logic [7:0] w_div_nxt;
   logic [1:0] w_cnt_nxt;
   logic [3:0] w_data_nxt;
   logic       w_parity_nxt;
   logic       w_tx_nxt;
   logic       w_busy_nxt;
   logic       w_done_nxt;
   logic       w_strobe_nxt;

   logic       w_start_edge;
   logic       w_bit_last;
   logic [1:0] w_cnt_inc;

   assign w_start_edge = w_start & ~r_start_q;
   assign w_bit_last   = (r_div == LP_DIV_LAST);
   assign w_cnt_inc    = r_cnt + 2'd1;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         r_state   <= ST_IDLE;
         r_div     <= 8'd0;
         r_cnt     <= 2'd0;
         r_data    <= 4'd0;
         r_parity  <= 1'b0;
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_strobe  <= 1'b0;
         r_start_q <= 1'b1;
      end else begin
         r_state   <= w_state_nxt;
         r_div     <= w_div_nxt;
         r_cnt     <= w_cnt_nxt;
         r_data    <= w_data_nxt;
         r_parity  <= w_parity_nxt;
         r_tx      <= w_tx_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_strobe  <= w_strobe_nxt;
         r_start_q <= w_start;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and registered-output logic.
   // Every output is computed here for the cycle after the edge, so
   // tx_line/busy/strobe change on the very edge a bit boundary occurs.
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt  = r_state;
      w_div_nxt    = r_div;
      w_cnt_nxt    = r_cnt;
      w_data_nxt   = r_data;
      w_parity_nxt = r_parity;
      w_tx_nxt     = r_tx;
      w_busy_nxt   = r_busy;
      w_done_nxt   = 1'b0;
      w_strobe_nxt = 1'b0;

      // Bit timing while a frame is in flight: the divider wraps to 0 at
      // each bit boundary and the strobe marks the first clock of the bit.
      // With BIT_CYCLES=1 every clock is a boundary, so the strobe stays high.
      if (r_state != ST_IDLE) begin
         if (w_bit_last) begin
            w_div_nxt    = 8'd0;
            w_strobe_nxt = 1'b1;
         end else begin
            w_div_nxt    = r_div + 8'd1;
         end
      end

      case (r_state)
         ST_IDLE: begin
            w_tx_nxt   = 1'b1;
            w_busy_nxt = 1'b0;
            w_div_nxt  = 8'd0;
            w_cnt_nxt  = 2'd0;
            // IDLE includes the done cycle, so a start edge there launches
            // the next frame back to back.
            if (w_start_edge) begin
               w_state_nxt  = ST_START;
               w_tx_nxt     = 1'b0;
               w_busy_nxt   = 1'b1;
               w_strobe_nxt = 1'b1;
               w_data_nxt   = w_data;
               w_parity_nxt = (^w_data) ^ w_parity_odd;
            end
         end

         ST_START: begin
            if (w_bit_last) begin
               w_state_nxt = ST_DATA;
               w_tx_nxt    = r_data[0];
               w_cnt_nxt   = 2'd0;
            end
         end

         ST_DATA: begin
            if (w_bit_last) begin
               if (r_cnt == 2'd3) begin
                  w_state_nxt = ST_PARITY;
                  w_tx_nxt    = r_parity;
               end else begin
                  w_cnt_nxt   = w_cnt_inc;
                  w_tx_nxt    = r_data[w_cnt_inc];
               end
            end
         end

         ST_PARITY: begin
            if (w_bit_last) begin
               w_state_nxt = ST_STOP;
               w_tx_nxt    = 1'b1;
               w_cnt_nxt   = 2'd0;
            end
         end

         ST_STOP: begin
            if (w_bit_last) begin
               if (r_cnt == LP_STOP_LAST) begin
                  // Frame complete: no strobe, line stays high.
                  w_state_nxt  = ST_IDLE;
                  w_busy_nxt   = 1'b0;
                  w_done_nxt   = 1'b1;
                  w_strobe_nxt = 1'b0;
                  w_cnt_nxt    = 2'd0;
               end else begin
                  w_cnt_nxt    = w_cnt_inc;
               end
            end
         end

         default: begin
            // Unused encodings recover to a quiet idle line.
            w_state_nxt  = ST_IDLE;
            w_tx_nxt     = 1'b1;
            w_busy_nxt   = 1'b0;
            w_div_nxt    = 8'd0;
            w_cnt_nxt    = 2'd0;
            w_strobe_nxt = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output packing
   // ------------------------------------------------------------------
   assign io_out = {r_parity, r_state, r_strobe, r_done, r_busy, r_tx};

endmodule

// File: tb/tb_tt_serial_frame_tx.sv
// Purpose : self-checking bench for tt_serial_frame_tx (two instances: 4 clk/bit + 1 stop, 1 clk/bit + 2 stop).
// Latency : n/a.
// Backpr. : n/a.

module tb_tt_serial_frame_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Per-instance stimulus; index 0 = BIT_CYCLES 4 / STOP_BITS 1, index 1 = BIT_CYCLES 1 / STOP_BITS 2.
   logic       rst_v   [2];
   logic       start_v [2];
   logic [3:0] data_v  [2];
   logic       podd_v  [2];
   logic [7:0] out_a;
   logic [7:0] out_b;

   tt_serial_frame_tx #(.BIT_CYCLES(4), .STOP_BITS(1)) u_dut_a (
      .io_in  ({podd_v[0], data_v[0], start_v[0], rst_v[0], clk}),
      .io_out (out_a)
   );

   tt_serial_frame_tx #(.BIT_CYCLES(1), .STOP_BITS(2)) u_dut_b (
      .io_in  ({podd_v[1], data_v[1], start_v[1], rst_v[1], clk}),
      .io_out (out_b)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
   endtask

   // ------------------------------------------------------------------
   // Reference model: a frame is a list of serial bits, each held for
   // B clocks; the expected output byte is computed from the clock
   // offset k since the accepting edge.
   // ------------------------------------------------------------------
   function automatic logic [7:0] frame_smp(input int k, input int b,
                                            input logic [3:0] d, input logic p);
      int         idx;
      logic       tx;
      logic [2:0] st;
      idx = k / b;
      if (idx == 0)      begin tx = 1'b0;            st = 3'd1; end
      else if (idx <= 4) begin tx = d[2'(idx - 1)];  st = 3'd2; end
      else if (idx == 5) begin tx = p;               st = 3'd3; end
      else               begin tx = 1'b1;            st = 3'd4; end
      return {p, st, (k % b == 0), 1'b0, 1'b1, tx};
   endfunction

   int         m_k   [2] = '{0, 0};
   logic       m_act [2] = '{1'b0, 1'b0};
   logic [3:0] m_d   [2] = '{4'd0, 4'd0};
   logic       m_p   [2] = '{1'b0, 1'b0};
   logic       m_sq  [2] = '{1'b1, 1'b1};
   logic [7:0] m_exp [2] = '{8'h01, 8'h01};

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int   b;
         int   s;
         logic e;
         b = (i == 0) ? 4 : 1;
         s = (i == 0) ? 1 : 2;
         if (rst_v[i]) begin
            m_act[i] = 1'b0;
            m_p[i]   = 1'b0;
            m_sq[i]  = 1'b1;
            m_exp[i] = 8'h01;
         end else begin
            e       = start_v[i] & ~m_sq[i];
            m_sq[i] = start_v[i];
            if (m_act[i]) begin
               m_k[i]++;
               if (m_k[i] == (6 + s) * b) begin
                  m_act[i] = 1'b0;
                  m_exp[i] = {m_p[i], 7'b000_0101};
               end else begin
                  m_exp[i] = frame_smp(m_k[i], b, m_d[i], m_p[i]);
               end
            end else if (e) begin
               m_act[i] = 1'b1;
               m_k[i]   = 0;
               m_d[i]   = data_v[i];
               m_p[i]   = (^data_v[i]) ^ podd_v[i];
               m_exp[i] = frame_smp(0, b, m_d[i], m_p[i]);
            end else begin
               m_exp[i] = {m_p[i], 7'b000_0001};
            end
         end
      end
      #1;
      check("model_a", 32'(out_a), 32'(m_exp[0]));
      check("model_b", 32'(out_b), 32'(m_exp[1]));
   end

   // ------------------------------------------------------------------
   // Table of single frames on instance A (4 clk/bit, 1 stop).
   // exp_bits[n] is the line level during serial bit n: start, d0..d3, parity, stop.
   // ------------------------------------------------------------------
   typedef struct {
      logic [3:0] data;
      logic       podd;
      logic       glitch;     // pulse start again mid-frame
      logic [6:0] exp_bits;
      logic       exp_p;
   } vec_t;

   vec_t rows [6];

   task automatic run_row(input vec_t v, input int r);
      logic [6:0] got_bits;
      int         busy_n;
      int         done_n;
      got_bits = '0;
      busy_n   = 0;
      done_n   = 0;
      @(negedge clk);
      start_v[0] = 1'b0; data_v[0] = v.data; podd_v[0] = v.podd;
      @(negedge clk);
      start_v[0] = 1'b1;
      for (int cyc = 0; cyc < 32; cyc++) begin
         @(negedge clk);
         if (cyc == 0) start_v[0] = 1'b0;
         if (cyc == 3) begin data_v[0] = ~v.data; podd_v[0] = ~v.podd; end
         if (v.glitch && cyc == 9)  start_v[0] = 1'b1;
         if (v.glitch && cyc == 10) start_v[0] = 1'b0;
         if (cyc < 28 && (cyc % 4) == 2) got_bits[3'(cyc / 4)] = out_a[0];
         busy_n += int'(out_a[1]);
         done_n += int'(out_a[2]);
      end
      check($sformatf("row%0d_bits", r), 32'(got_bits), 32'(v.exp_bits));
      check($sformatf("row%0d_busy_len", r), 32'(busy_n), 32'd28);
      check($sformatf("row%0d_done_cnt", r), 32'(done_n), 32'd1);
      check($sformatf("row%0d_parity_out", r), 32'(out_a[7]), 32'(v.exp_p));
   endtask

   // Start re-raised in the done cycle: next frame starts on the following edge.
   task automatic run_b2b();
      logic seen;
      logic chk;
      int   done_cyc;
      int   done_n;
      seen = 1'b0; chk = 1'b0; done_cyc = -1; done_n = 0;
      @(negedge clk);
      start_v[0] = 1'b0; data_v[0] = 4'h3; podd_v[0] = 1'b0;
      @(negedge clk);
      start_v[0] = 1'b1;
      for (int cyc = 0; cyc < 70; cyc++) begin
         @(negedge clk);
         if (cyc == 0) start_v[0] = 1'b0;
         if (chk) begin
            check("b2b_next_start", 32'({out_a[6:4], out_a[1], out_a[0]}), 32'({3'd1, 1'b1, 1'b0}));
            chk = 1'b0;
            start_v[0] = 1'b0;
         end
         if (out_a[2] && !seen) begin
            seen = 1'b1; chk = 1'b1; done_cyc = cyc; start_v[0] = 1'b1;
         end
         done_n += int'(out_a[2]);
      end
      check("b2b_done_cycle", 32'(done_cyc), 32'd28);
      check("b2b_done_cnt", 32'(done_n), 32'd2);
   endtask

   // Reset at clock 12 of a frame with start held high through release.
   task automatic run_mid_rst();
      int busy_n;
      int done_n;
      busy_n = 0; done_n = 0;
      @(negedge clk);
      start_v[0] = 1'b0; data_v[0] = 4'h5; podd_v[0] = 1'b0;
      @(negedge clk);
      start_v[0] = 1'b1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         if (cyc == 0) start_v[0] = 1'b0;
      end
      rst_v[0] = 1'b1; start_v[0] = 1'b1;
      @(negedge clk);
      check("mid_rst_out", 32'(out_a), 32'h01);
      rst_v[0] = 1'b0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(negedge clk);
         busy_n += int'(out_a[1]);
         done_n += int'(out_a[2]);
      end
      check("mid_rst_no_frame", 32'(busy_n), 32'd0);
      check("mid_rst_no_done", 32'(done_n), 32'd0);
      start_v[0] = 1'b0;
      @(negedge clk);
      start_v[0] = 1'b1;
      @(negedge clk);
      check("mid_rst_restart_state", 32'(out_a[6:4]), 32'd1);
      start_v[0] = 1'b0;
      repeat (30) @(negedge clk);
   endtask

   // Instance B: 1 clock per bit, 2 stop bits -> 8-clock frame.
   task automatic run_fast();
      int         strobe_n;
      int         busy_n;
      int         stop_n;
      logic [7:0] bits;
      logic       done8;
      strobe_n = 0; busy_n = 0; stop_n = 0; bits = '0; done8 = 1'b0;
      @(negedge clk);
      start_v[1] = 1'b0; data_v[1] = 4'h6; podd_v[1] = 1'b1;
      @(negedge clk);
      start_v[1] = 1'b1;
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(negedge clk);
         if (cyc == 0) start_v[1] = 1'b0;
         if (cyc < 8) begin
            strobe_n += int'(out_b[3]);
            busy_n   += int'(out_b[1]);
            stop_n   += int'(out_b[6:4] == 3'd4);
            bits[3'(cyc)] = out_b[0];
         end
         if (cyc == 8) done8 = out_b[2];
      end
      check("fast_strobe_cnt", 32'(strobe_n), 32'd8);
      check("fast_busy_len", 32'(busy_n), 32'd8);
      check("fast_stop_cycles", 32'(stop_n), 32'd2);
      check("fast_done_at_8", 32'(done8), 32'd1);
      check("fast_bits", 32'(bits), 32'b1110_1100);
   endtask

   initial begin
      int busy_n;

      rows[0] = '{4'hA, 1'b0, 1'b0, 7'b1010100, 1'b0};
      rows[1] = '{4'h7, 1'b1, 1'b0, 7'b1001110, 1'b0};
      rows[2] = '{4'h7, 1'b0, 1'b0, 7'b1101110, 1'b1};
      rows[3] = '{4'h0, 1'b0, 1'b1, 7'b1000000, 1'b0};
      rows[4] = '{4'hF, 1'b1, 1'b0, 7'b1111110, 1'b1};
      rows[5] = '{4'h1, 1'b0, 1'b1, 7'b1100010, 1'b1};

      for (int i = 0; i < 2; i++) begin
         rst_v[i] = 1'b1; start_v[i] = 1'b1; data_v[i] = 4'd0; podd_v[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      check("reset_out_a", 32'(out_a), 32'h01);
      check("reset_out_b", 32'(out_b), 32'h01);
      rst_v[0] = 1'b0; rst_v[1] = 1'b0;
      busy_n = 0;
      repeat (6) begin
         @(negedge clk);
         busy_n += int'(out_a[1]) + int'(out_b[1]);
      end
      check("start_held_through_reset", 32'(busy_n), 32'd0);
      start_v[0] = 1'b0; start_v[1] = 1'b0;
      @(negedge clk);

      for (int r = 0; r < 6; r++) run_row(rows[r], r);
      run_b2b();
      run_mid_rst();
      run_fast();

      // Random traffic on both instances, checked cycle by cycle by the model.
      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if ($urandom_range(0, 3) == 0) start_v[i] = ~start_v[i];
            data_v[i] = 4'($urandom_range(0, 15));
            podd_v[i] = 1'($urandom_range(0, 1));
            rst_v[i]  = ($urandom_range(0, 99) == 0);
         end
      end
      rst_v[0] = 1'b0; rst_v[1] = 1'b0;
      start_v[0] = 1'b0; start_v[1] = 1'b0;
      repeat (40) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
